// File: rtl/bfly5_pkg.sv
// Shared types and constants for the radix-5 group sequencer and its butterfly.
// Twiddles are 18-bit signed Q1.16 values of cos/sin(2*pi*m/5).
package bfly5_pkg;

    typedef enum logic [1:0] {
        GATHER,
        COMPUTE,
        SCATTER
    } state_t;

    localparam int RADIX       = 5;
    localparam int IDX_W       = 3;
    localparam int PRESCALE_SH = 3;
    localparam int TW_FRAC     = 16;

    function automatic logic signed [17:0] tw_cos(input int m);
        case (m)
            0:       tw_cos = 18'sd65536;
            1, 4:    tw_cos = 18'sd20252;
            default: tw_cos = -18'sd53020;
        endcase
    endfunction

    // W^m = cos - j*sin, so sin carries the sign of the rotation direction.
    function automatic logic signed [17:0] tw_sin(input int m);
        case (m)
            0:       tw_sin = 18'sd0;
            1:       tw_sin = 18'sd62328;
            2:       tw_sin = 18'sd38521;
            3:       tw_sin = -18'sd38521;
            default: tw_sin = -18'sd62328;
        endcase
    endfunction

endpackage

// File: rtl/Butterfly5.sv
// Combinational 5-point DFT: y[k] = sum x[n] * W^(n*k), rounded back to WIDTH bits.
// Results wrap on overflow; no growth bits are kept on the outputs.
module Butterfly5
    import bfly5_pkg::*;
#(
    parameter int WIDTH = 15
) (
    input  logic [RADIX-1:0][WIDTH-1:0] x_re,
    input  logic [RADIX-1:0][WIDTH-1:0] x_im,
    output logic [RADIX-1:0][WIDTH-1:0] y_re,
    output logic [RADIX-1:0][WIDTH-1:0] y_im
);

    // Wide enough for one WIDTH x 18 product plus the ten-term sum.
    localparam int SW = WIDTH + 18 + 4;
    localparam logic signed [SW-1:0] RND = SW'(1 << (TW_FRAC - 1));

    for (genvar gi = 0; gi < RADIX; gi++) begin : g_out
        logic signed [SW-1:0] term_re [RADIX];
        logic signed [SW-1:0] term_im [RADIX];
        logic signed [SW-1:0] acc_re;
        logic signed [SW-1:0] acc_im;

        for (genvar gn = 0; gn < RADIX; gn++) begin : g_term
            localparam logic signed [SW-1:0] TCW = SW'(tw_cos((gi * gn) % RADIX));
            localparam logic signed [SW-1:0] TSW = SW'(tw_sin((gi * gn) % RADIX));
            logic signed [SW-1:0] xr;
            logic signed [SW-1:0] xi;

            assign xr = SW'($signed(x_re[gn]));
            assign xi = SW'($signed(x_im[gn]));
            assign term_re[gn] = xr * TCW + xi * TSW;
            assign term_im[gn] = xi * TCW - xr * TSW;
        end

        assign acc_re = term_re[0] + term_re[1] + term_re[2] + term_re[3] + term_re[4];
        assign acc_im = term_im[0] + term_im[1] + term_im[2] + term_im[3] + term_im[4];

        assign y_re[gi] = WIDTH'((acc_re + RND) >>> TW_FRAC);
        assign y_im[gi] = WIDTH'((acc_im + RND) >>> TW_FRAC);
    end

endmodule

// File: rtl/bfly5_group_sequencer.sv
// Gathers 5 samples, runs one shared Butterfly5, and re-serializes y0..y4 downstream.
// Define BFLY5_PRESCALE_EN to arithmetic-shift each accepted component right by 3.
module bfly5_group_sequencer
    import bfly5_pkg::*;
#(
    parameter int WIDTH  = 15,
    parameter int GROUPS = 12,
    parameter int GCNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_re,
    input  logic [WIDTH-1:0]  in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_re,
    output logic [WIDTH-1:0]  out_im,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic [GCNT_W-1:0] group_cnt,
    output logic              busy
);

    state_t                      state_reg, state_next;
    logic [IDX_W-1:0]            cnt_reg, cnt_next;
    logic [IDX_W-1:0]            out_idx_reg, out_idx_next;
    logic [GCNT_W-1:0]           group_cnt_reg, group_cnt_next;
    logic [RADIX-1:0][WIDTH-1:0] x_re_reg, x_im_reg;
    logic [RADIX-1:0][WIDTH-1:0] y_re_reg, y_im_reg;
    logic [RADIX-1:0][WIDTH-1:0] bf_re, bf_im;
    logic [WIDTH-1:0]            in_re_s, in_im_s;
    logic                        accept;
    logic                        emit;

`ifdef BFLY5_PRESCALE_EN
    assign in_re_s = WIDTH'($signed(in_re) >>> PRESCALE_SH);
    assign in_im_s = WIDTH'($signed(in_im) >>> PRESCALE_SH);
`else
    assign in_re_s = in_re;
    assign in_im_s = in_im;
`endif

    assign in_ready  = !rst && (state_reg == GATHER);
    assign out_valid = (state_reg == SCATTER);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_idx_next   = out_idx_reg;
        group_cnt_next = group_cnt_reg;
        unique case (state_reg)
            GATHER: begin
                if (accept) begin
                    if (cnt_reg == IDX_W'(RADIX - 1)) begin
                        state_next = COMPUTE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                state_next   = SCATTER;
                out_idx_next = '0;
            end
            SCATTER: begin
                if (emit) begin
                    if (out_idx_reg == IDX_W'(RADIX - 1)) begin
                        state_next   = GATHER;
                        out_idx_next = '0;
                        cnt_next     = '0;
                        group_cnt_next = (group_cnt_reg == GCNT_W'(GROUPS - 1))
                                       ? '0 : group_cnt_reg + 1'b1;
                    end else begin
                        out_idx_next = out_idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = GATHER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= GATHER;
            cnt_reg       <= '0;
            out_idx_reg   <= '0;
            group_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_idx_reg   <= out_idx_next;
            group_cnt_reg <= group_cnt_next;
        end
    end

    // Sample and result registers need no reset: outputs are gated by state.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_re_reg[cnt_reg] <= in_re_s;
            x_im_reg[cnt_reg] <= in_im_s;
        end
        if (state_reg == COMPUTE) begin
            y_re_reg <= bf_re;
            y_im_reg <= bf_im;
        end
    end

    Butterfly5 #(
        .WIDTH (WIDTH)
    ) u_bfly (
        .x_re (x_re_reg),
        .x_im (x_im_reg),
        .y_re (bf_re),
        .y_im (bf_im)
    );

    assign out_re    = out_valid ? y_re_reg[out_idx_reg] : '0;
    assign out_im    = out_valid ? y_im_reg[out_idx_reg] : '0;
    assign out_idx   = out_idx_reg;
    assign out_last  = out_valid && (out_idx_reg == IDX_W'(RADIX - 1))
                    && (group_cnt_reg == GCNT_W'(GROUPS - 1));
    assign group_cnt = group_cnt_reg;
    assign busy      = !((state_reg == GATHER) && (cnt_reg == '0));

endmodule

// File: tb/tb_bfly5_group_sequencer.sv
// Directed bench for bfly5_group_sequencer with GROUPS=2 so frame wrap is quick to reach.
// Expected values are hand-derived; BFLY5_PRESCALE_EN selects the prescaled expectations.
module tb_bfly5_group_sequencer;

    localparam int WIDTH  = 15;
    localparam int GROUPS = 2;
    localparam int GCNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_re;
    logic [WIDTH-1:0]  in_im;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_re;
    logic [WIDTH-1:0]  out_im;
    logic [2:0]        out_idx;
    logic              out_last;
    logic [GCNT_W-1:0] group_cnt;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    int obs_re [5];
    int obs_im [5];
    int obs_idx [5];
    int obs_last [5];
    int obs_gc [5];

    bfly5_group_sequencer #(
        .WIDTH  (WIDTH),
        .GROUPS (GROUPS),
        .GCNT_W (GCNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .group_cnt (group_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pre(input int v);
`ifdef BFLY5_PRESCALE_EN
        return v >>> 3;
`else
        return v;
`endif
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic send_group(input int re [5], input int im [5]);
        int waited;
        for (int i = 0; i < 5; i++) begin
            waited   = 0;
            in_valid = 1'b1;
            in_re    = WIDTH'(re[i]);
            in_im    = WIDTH'(im[i]);
            while (!in_ready && waited < 30) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
                in_valid = 1'b0;
                return;
            end
            $display("in  #%0d re=%0d im=%0d", i, re[i], im[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect_group();
        int waited;
        for (int k = 0; k < 5; k++) obs_idx[k] = -1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            waited = 0;
            while (!out_valid && waited < 30) begin
                @(posedge clk); #1;
                waited++;
            end
            if (!out_valid) begin
                n_cmp++;
                n_bad++;
                $display("FAIL collect_timeout: out_valid=%0b required 1 at k=%0d", out_valid, k);
                out_ready = 1'b0;
                return;
            end
            obs_re[k]   = int'($signed(out_re));
            obs_im[k]   = int'($signed(out_im));
            obs_idx[k]  = int'(out_idx);
            obs_last[k] = int'(out_last);
            obs_gc[k]   = int'(group_cnt);
            $display("out #%0d idx=%0d re=%0d im=%0d last=%0d gcnt=%0d",
                     k, obs_idx[k], obs_re[k], obs_im[k], obs_last[k], obs_gc[k]);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_during_rst: got %0b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (group_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_group_cnt: got %0d want 0", group_cnt); end
        n_cmp++; if (out_idx !== 3'd0 || out_last !== 1'b0) begin n_bad++; $display("FAIL reset_idx_last: got idx=%0d last=%0b want 0/0", out_idx, out_last); end
        n_cmp++; if (out_re !== '0 || out_im !== '0) begin n_bad++; $display("FAIL reset_out_data: got %0d/%0d want 0/0", out_re, out_im); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_after: got %0b want 1", in_ready); end
        $display("reset done");
    endtask

    task automatic test_impulse();
        int re [5];
        int im [5];
        int exp_re;
        re = '{100, 0, 0, 0, 0};
        im = '{0, 0, 0, 0, 0};
        exp_re = pre(100);
        send_group(re, im);
        // One cycle after the 5th accept: COMPUTE, nothing out yet.
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL impulse_compute_cycle: got valid=%0b ready=%0b busy=%0b want 0/0/1", out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin
            n_bad++; $display("FAIL impulse_latency: got valid=%0b idx=%0d want 1/0", out_valid, out_idx);
        end
        collect_group();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (obs_idx[k] != k) begin n_bad++; $display("FAIL impulse_idx k=%0d: got %0d want %0d", k, obs_idx[k], k); end
            n_cmp++; if (iabs(obs_re[k] - exp_re) > 1 || iabs(obs_im[k]) > 1) begin
                n_bad++; $display("FAIL impulse_data k=%0d: got %0d/%0d want %0d/0 +-1", k, obs_re[k], obs_im[k], exp_re);
            end
            n_cmp++; if (obs_last[k] != 0 || obs_gc[k] != 0) begin
                n_bad++; $display("FAIL impulse_last_gc k=%0d: got last=%0d gc=%0d want 0/0", k, obs_last[k], obs_gc[k]);
            end
        end
        n_cmp++; if (group_cnt !== 4'd1 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL impulse_after: got gc=%0d ready=%0b want 1/1", group_cnt, in_ready);
        end
    endtask

    task automatic test_dc();
        int re [5];
        int im [5];
        int exp_y0;
        re = '{10, 10, 10, 10, 10};
        im = '{0, 0, 0, 0, 0};
        exp_y0 = 5 * pre(10);
        send_group(re, im);
        collect_group();
        n_cmp++; if (iabs(obs_re[0] - exp_y0) > 1 || iabs(obs_im[0]) > 1) begin
            n_bad++; $display("FAIL dc_y0: got %0d/%0d want %0d/0", obs_re[0], obs_im[0], exp_y0);
        end
        for (int k = 1; k < 5; k++) begin
            n_cmp++; if (iabs(obs_re[k]) > 2 || iabs(obs_im[k]) > 2) begin
                n_bad++; $display("FAIL dc_yk k=%0d: got %0d/%0d want |.|<=2", k, obs_re[k], obs_im[k]);
            end
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (obs_last[k] != ((k == 4) ? 1 : 0) || obs_gc[k] != 1) begin
                n_bad++; $display("FAIL dc_last_gc k=%0d: got last=%0d gc=%0d want %0d/1", k, obs_last[k], obs_gc[k], (k == 4) ? 1 : 0);
            end
        end
        n_cmp++; if (group_cnt !== 4'd0) begin n_bad++; $display("FAIL dc_gc_wrap: got %0d want 0", group_cnt); end
    endtask

    task automatic test_frame_wrap();
        int re [5];
        int im [5];
        re = '{100, 0, 0, 0, 0};
        im = '{0, 0, 0, 0, 0};
        send_group(re, im);
        collect_group();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (obs_last[k] != 0 || obs_gc[k] != 0 || obs_idx[k] != k) begin
                n_bad++; $display("FAIL wrap_group k=%0d: got last=%0d gc=%0d idx=%0d want 0/0/%0d", k, obs_last[k], obs_gc[k], obs_idx[k], k);
            end
        end
        n_cmp++; if (group_cnt !== 4'd1) begin n_bad++; $display("FAIL wrap_gc_after: got %0d want 1", group_cnt); end
    endtask

    task automatic test_reset_mid_scatter();
        int re [5];
        int im [5];
        int waited;
        re = '{100, 0, 0, 0, 0};
        im = '{0, 0, 0, 0, 0};
        send_group(re, im);
        waited = 0;
        while (!out_valid && waited < 30) begin @(posedge clk); #1; waited++; end
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd2) begin
            n_bad++; $display("FAIL rstmid_pre: got valid=%0b idx=%0d want 1/2", out_valid, out_idx);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        $display("reset pulse mid-scatter");
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_handshake: got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
        end
        n_cmp++; if (group_cnt !== 4'd0 || busy !== 1'b0 || out_idx !== 3'd0) begin
            n_bad++; $display("FAIL rstmid_state: got gc=%0d busy=%0b idx=%0d want 0/0/0", group_cnt, busy, out_idx);
        end
        send_group(re, im);
        collect_group();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (obs_idx[k] != k || iabs(obs_re[k] - pre(100)) > 1 || iabs(obs_im[k]) > 1 || obs_gc[k] != 0) begin
                n_bad++; $display("FAIL rstmid_fresh k=%0d: got idx=%0d re=%0d im=%0d gc=%0d want %0d/%0d/0/0",
                                  k, obs_idx[k], obs_re[k], obs_im[k], obs_gc[k], k, pre(100));
            end
        end
    endtask

    task automatic test_backpressure();
        int re [5];
        int im [5];
        int bp_re [5];
        int bp_im [5];
        int waited;
        logic [WIDTH-1:0] h_re;
        logic [WIDTH-1:0] h_im;
        re = '{100, 50, 0, 0, 0};
        im = '{0, 0, 0, 0, 0};
`ifdef BFLY5_PRESCALE_EN
        bp_re = '{18, 14, 7, 7, 14};
        bp_im = '{0, -6, -4, 4, 6};
`else
        bp_re = '{150, 115, 60, 60, 115};
        bp_im = '{0, -48, -29, 29, 48};
`endif
        send_group(re, im);
        waited = 0;
        while (!out_valid && waited < 30) begin @(posedge clk); #1; waited++; end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                out_ready = 1'b0;
                h_re = out_re;
                h_im = out_im;
                for (int c = 0; c < 7; c++) begin
                    @(posedge clk); #1;
                    n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_re !== h_re || out_im !== h_im || in_ready !== 1'b0) begin
                        n_bad++; $display("FAIL bp_hold c=%0d: got valid=%0b idx=%0d re=%0d im=%0d ready=%0b want 1/2/%0d/%0d/0",
                                          c, out_valid, out_idx, out_re, out_im, in_ready, h_re, h_im);
                    end
                end
                out_ready = 1'b1;
            end
            $display("out #%0d idx=%0d re=%0d im=%0d last=%0b gcnt=%0d",
                     k, out_idx, $signed(out_re), $signed(out_im), out_last, group_cnt);
            n_cmp++; if (out_valid !== 1'b1 || out_idx !== 3'(k)) begin
                n_bad++; $display("FAIL bp_order k=%0d: got valid=%0b idx=%0d want 1/%0d", k, out_valid, out_idx, k);
            end
            n_cmp++; if (iabs(int'($signed(out_re)) - bp_re[k]) > 1 || iabs(int'($signed(out_im)) - bp_im[k]) > 1) begin
                n_bad++; $display("FAIL bp_data k=%0d: got %0d/%0d want %0d/%0d +-1", k, $signed(out_re), $signed(out_im), bp_re[k], bp_im[k]);
            end
            n_cmp++; if (out_last !== ((k == 4) ? 1'b1 : 1'b0)) begin
                n_bad++; $display("FAIL bp_last k=%0d: got %0b want %0b", k, out_last, (k == 4));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_cmp++; if (group_cnt !== 4'd0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL bp_after: got gc=%0d busy=%0b want 0/0", group_cnt, busy);
        end
    endtask

`ifdef BFLY5_PRESCALE_EN
    task automatic test_prescale();
        int re [5];
        int im [5];
        re = '{16000, 16000, 16000, 16000, 16000};
        im = '{0, 0, 0, 0, 0};
        send_group(re, im);
        collect_group();
        n_cmp++; if (iabs(obs_re[0] - 10000) > 1 || iabs(obs_im[0]) > 1) begin
            n_bad++; $display("FAIL prescale_y0: got %0d/%0d want 10000/0", obs_re[0], obs_im[0]);
        end
        for (int k = 1; k < 5; k++) begin
            n_cmp++; if (iabs(obs_re[k]) > 2 || iabs(obs_im[k]) > 2) begin
                n_bad++; $display("FAIL prescale_yk k=%0d: got %0d/%0d want |.|<=2", k, obs_re[k], obs_im[k]);
            end
        end
        re = '{-1, 0, 0, 0, 0};
        send_group(re, im);
        collect_group();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (obs_re[k] != -1 || obs_im[k] != 0) begin
                n_bad++; $display("FAIL prescale_neg k=%0d: got %0d/%0d want -1/0", k, obs_re[k], obs_im[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_frame_wrap();
        test_reset_mid_scatter();
        test_backpressure();
`ifdef BFLY5_PRESCALE_EN
        test_prescale();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
